vending_machine_param: RTL and testbench
========================================

Name: vending_machine_param

Overview:
- Parametrised successor to the fixed-price vending machine FSM.
- Accepts three coin denominations, accumulates credit and pulses `prod` when credit reaches PRICE.
- Returns surplus credit as a serial stream of `change` pulses, one CHANGE_UNIT each, throttled by a dispenser-ready handshake.
- Adds cancel/refund and busy-time coin rejection; sits between the coin acceptor front-end and the product/change actuators.

Parameters:
- CREDIT_W, 8, width of credit register and `credit` port.
- PRICE, 15, product price in base units.
- COIN1_VAL, 5, value of coin code 2'b01.
- COIN2_VAL, 10, value of coin code 2'b10.
- COIN3_VAL, 25, value of coin code 2'b11.
- CHANGE_UNIT, 5, value returned per `change` pulse.
- Constraints: PRICE and all COINx_VAL are integer multiples of CHANGE_UNIT, and PRICE-1+COIN3_VAL < 2**CREDIT_W. Violations are flagged by a simulation-time check.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, asynchronous active-low reset; one clock domain.
- coin, input, 2, coin code sampled each rising edge: 00 none, 01/10/11 denominations 1/2/3.
- cancel, input, 1, refund request, level-sampled.
- chg_ready, input, 1, change dispenser can accept a unit this cycle.
- prod, output, 1, one-cycle product-release pulse.
- change, output, 1, one-cycle pulse per CHANGE_UNIT dispensed.
- coin_reject, output, 1, one-cycle pulse: the sampled coin was not credited.
- credit, output, CREDIT_W, current credit.
- busy, output, 1, high in VEND or CHANGE.

Behaviour:
- All outputs are registered.
- While rst=0, asynchronously: state=IDLE; credit=0; prod, change, coin_reject and busy=0.
- States: IDLE (credit 0), COLLECT (0<credit<PRICE), VEND, CHANGE.
- IDLE/COLLECT, coin≠00, cancel=0:
  - nc = credit + value.
  - nc ≥ PRICE: next state VEND, credit <= nc-PRICE.
  - nc < PRICE: next state COLLECT, credit <= nc.
- Latency: coin sampled at edge N produces prod=1 during cycle N+1, for exactly one cycle.
- VEND (one cycle): prod=1. Next state is CHANGE if credit>0, else IDLE.
- CHANGE:
  - Each edge with chg_ready=1: change=1 next cycle and credit -= CHANGE_UNIT.
  - After the pulse that brings credit to 0: next state IDLE, busy=0.
  - chg_ready=0: change=0 and credit is held, with no timeout.
- cancel=1 in COLLECT: next state CHANGE; the full credit is refunded via change pulses; no prod.
- cancel in IDLE is ignored.
- cancel in VEND/CHANGE is ignored.
- cancel and coin≠00 on the same edge in COLLECT: cancel wins, the coin is rejected (coin_reject=1) and not credited.
- coin≠00 while in VEND or CHANGE: coin_reject=1 next cycle, credit unchanged.
- Held coin code is counted once per edge; the front-end guarantees single-cycle coin codes.
- Reset mid-operation (any state): immediate return to reset values; the credit in flight is discarded with no pulses.
- credit never wraps; this is guaranteed by the width constraint.

Test Plan:
- Reset:
  - rst=0 for 2 cycles mid-stream -> prod, change, coin_reject and busy=0; credit=0.
  - After release, state=IDLE.
- Exact price:
  - coin 01 then 10 on consecutive edges -> credit 5, then prod=1 for one cycle.
  - credit=0 after the vend, change never pulses, back to IDLE.
- Overpay:
  - single coin 11 (25) with chg_ready=1 -> prod pulse, then credit 10, then exactly 2 change pulses (credit 5, then 0).
  - busy high from the prod cycle to the last change cycle.
- Cancel/refund:
  - coin 10 (credit 10), then cancel=1 -> no prod; 2 change pulses; credit 0.
  - cancel+coin 01 on the same edge -> coin_reject pulse, and the credit refunded is still 10.
- Stall and busy reject:
  - overpay with 25 and chg_ready=0 for 4 cycles -> change=0, credit held at 10.
  - coin 01 during the stall -> coin_reject=1, credit stays 10.
  - chg_ready=1 -> 2 pulses complete the refund.
- Reset mid-CHANGE:
  - assert rst=0 after the first change pulse of a 25-coin vend -> outputs 0 asynchronously, credit 0, no further change pulses after release.

Source files
------------

// File: rtl/vending_machine_param.sv
// vending_machine_param: coin-accumulating vending FSM with a product pulse and
// a serial change/refund stream gated by a dispenser-ready handshake.
module vending_machine_param #(
    parameter int CREDIT_W    = 8,
    parameter int PRICE       = 15,
    parameter int COIN1_VAL   = 5,
    parameter int COIN2_VAL   = 10,
    parameter int COIN3_VAL   = 25,
    parameter int CHANGE_UNIT = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin,
    input  logic                cancel,
    input  logic                chg_ready,
    output logic                prod,
    output logic                change,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);
    if (PRICE % CHANGE_UNIT != 0 || COIN1_VAL % CHANGE_UNIT != 0 ||
        COIN2_VAL % CHANGE_UNIT != 0 || COIN3_VAL % CHANGE_UNIT != 0 ||
        PRICE - 1 + COIN3_VAL >= 2 ** CREDIT_W) begin : g_param_err
        $error("vending_machine_param: illegal parameter combination");
    end

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] UNIT_C  = CREDIT_W'(CHANGE_UNIT);
    localparam logic [CREDIT_W-1:0] C1_C    = CREDIT_W'(COIN1_VAL);
    localparam logic [CREDIT_W-1:0] C2_C    = CREDIT_W'(COIN2_VAL);
    localparam logic [CREDIT_W-1:0] C3_C    = CREDIT_W'(COIN3_VAL);

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d, coin_val, nc;
    logic                prod_q, prod_d, change_q, change_d;
    logic                reject_q, reject_d, busy_q, busy_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            prod_q   <= 1'b0;
            change_q <= 1'b0;
            reject_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            prod_q   <= prod_d;
            change_q <= change_d;
            reject_q <= reject_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        change_d = 1'b0;
        reject_d = 1'b0;
        coin_val = coin == 2'b01 ? C1_C : coin == 2'b10 ? C2_C : coin == 2'b11 ? C3_C : '0;
        nc       = credit_q + coin_val;
        case (state_q)
            IDLE, COLLECT: begin
                if (cancel && state_q == COLLECT) begin
                    state_d  = CHANGE;
                    reject_d = coin != 2'b00;
                end else if (coin != 2'b00) begin
                    state_d  = nc >= PRICE_C ? VEND : COLLECT;
                    credit_d = nc >= PRICE_C ? nc - PRICE_C : nc;
                end
            end
            VEND: begin
                reject_d = coin != 2'b00;
                state_d  = credit_q != '0 ? CHANGE : IDLE;
            end
            CHANGE: begin
                reject_d = coin != 2'b00;
                // stay one extra cycle after the last pulse so busy covers it
                if (credit_q == '0) begin
                    state_d = IDLE;
                end else if (chg_ready) begin
                    credit_d = credit_q - UNIT_C;
                    change_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        prod_d = state_d == VEND;
        busy_d = state_d == VEND || state_d == CHANGE;
    end

    assign prod        = prod_q;
    assign change      = change_q;
    assign coin_reject = reject_q;
    assign credit      = credit_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_vending_machine_param.sv
// tb_vending_machine_param: directed and random stimulus checked against an
// integer-arithmetic reference model of the vending rules.
module tb_vending_machine_param;
    localparam int CW = 8, PRICE = 15, V1 = 5, V2 = 10, V3 = 25, UNIT = 5;

    logic          clk = 1'b0, rst = 1'b0, cancel = 1'b0, chg_ready = 1'b0;
    logic [1:0]    coin = 2'b00;
    logic          prod, change, coin_reject, busy;
    logic [CW-1:0] credit;

    int checks = 0, errors = 0;
    int m_credit = 0;
    bit m_vend = 0, m_pay = 0;
    bit e_prod = 0, e_change = 0, e_rej = 0;

    vending_machine_param #(.CREDIT_W(CW), .PRICE(PRICE), .COIN1_VAL(V1), .COIN2_VAL(V2),
                            .COIN3_VAL(V3), .CHANGE_UNIT(UNIT)) dut (
        .clk(clk), .rst(rst), .coin(coin), .cancel(cancel), .chg_ready(chg_ready),
        .prod(prod), .change(change), .coin_reject(coin_reject), .credit(credit), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".prod"}, {31'd0, prod}, {31'd0, e_prod});
        chk({tag, ".change"}, {31'd0, change}, {31'd0, e_change});
        chk({tag, ".reject"}, {31'd0, coin_reject}, {31'd0, e_rej});
        chk({tag, ".credit"}, {24'd0, credit}, m_credit);
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, m_vend | m_pay});
    endtask

    task automatic model_reset();
        m_credit = 0; m_vend = 0; m_pay = 0;
        e_prod = 0; e_change = 0; e_rej = 0;
    endtask

    // one clock: product is owed after a vend, refund drains in UNIT steps,
    // and coins arriving while the machine is occupied are refused
    task automatic step(input string tag, input logic [1:0] c, input logic k, input logic r);
        int val;
        coin = c; cancel = k; chg_ready = r;
        @(posedge clk);
        val = c == 2'd1 ? V1 : c == 2'd2 ? V2 : c == 2'd3 ? V3 : 0;
        e_change = 0;
        e_rej = 0;
        if (m_vend) begin
            e_rej = c != 0;
            m_vend = 0;
            m_pay = m_credit > 0;
        end else if (m_pay) begin
            e_rej = c != 0;
            if (m_credit == 0) m_pay = 0;
            else if (r) begin
                m_credit -= UNIT;
                e_change = 1;
            end
        end else if (k && m_credit > 0) begin
            m_pay = 1;
            e_rej = c != 0;
        end else if (c != 0) begin
            m_credit += val;
            if (m_credit >= PRICE) begin
                m_credit -= PRICE;
                m_vend = 1;
            end
        end
        e_prod = m_vend;
        #1;
        chk_all(tag);
    endtask

    task automatic idle_steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 2'b00, 1'b0, 1'b1);
    endtask

    initial begin
        model_reset();
        #12;
        chk_all("reset");
        rst = 1'b1;
        idle_steps("post_reset", 2);

        step("exact_c1", 2'b01, 1'b0, 1'b1);
        chk("exact_credit5", {24'd0, credit}, 5);
        step("exact_c2", 2'b10, 1'b0, 1'b1);
        chk("exact_prod", {31'd0, prod}, 1);
        idle_steps("exact_after", 3);

        step("over_c3", 2'b11, 1'b0, 1'b1);
        chk("over_credit10", {24'd0, credit}, 10);
        idle_steps("over_drain", 4);

        step("cancel_c2", 2'b10, 1'b0, 1'b1);
        step("cancel", 2'b00, 1'b1, 1'b1);
        chk("cancel_no_prod", {31'd0, prod}, 0);
        idle_steps("cancel_drain", 4);

        step("cc_c2", 2'b10, 1'b0, 1'b0);
        step("cc_both", 2'b01, 1'b1, 1'b0);
        chk("cc_reject", {31'd0, coin_reject}, 1);
        chk("cc_credit10", {24'd0, credit}, 10);
        idle_steps("cc_drain", 4);

        step("stall_c3", 2'b11, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step("stall_hold", 2'b00, 1'b0, 1'b0);
        step("stall_coin", 2'b01, 1'b0, 1'b0);
        chk("stall_credit10", {24'd0, credit}, 10);
        idle_steps("stall_drain", 4);

        step("mid_c3", 2'b11, 1'b0, 1'b1);
        step("mid_vend", 2'b00, 1'b0, 1'b1);
        step("mid_pulse1", 2'b00, 1'b0, 1'b1);
        chk("mid_change1", {31'd0, change}, 1);
        #3 rst = 1'b0;
        #1;
        model_reset();
        chk_all("mid_async");
        repeat (2) @(posedge clk);
        #2;
        chk_all("mid_held");
        rst = 1'b1;
        idle_steps("mid_after", 4);

        for (int i = 0; i < 400; i++) begin
            logic [1:0] c;
            c = $urandom_range(0, 2) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
            step("rand", c, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
        end
        idle_steps("final_drain", 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
